// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage.
// Holds the ALU/branch opcode encoding carried on id_control, the EX FSM
// state encoding and small helpers shared by ex_stage and its ALU.
package ex_stage_pkg;

  typedef logic [3:0] alu_op_t;

  // ALU operations
  localparam alu_op_t ALU_ADD   = 4'd0;
  localparam alu_op_t ALU_SUB   = 4'd1;   // also used for BEQ
  localparam alu_op_t ALU_AND   = 4'd2;
  localparam alu_op_t ALU_OR    = 4'd3;
  localparam alu_op_t ALU_XOR   = 4'd4;
  localparam alu_op_t ALU_SLL   = 4'd5;
  localparam alu_op_t ALU_SRL   = 4'd6;
  localparam alu_op_t ALU_SRA   = 4'd7;
  localparam alu_op_t ALU_SLT   = 4'd8;
  localparam alu_op_t ALU_SLTU  = 4'd9;
  // Branch compares: the ALU result is zero exactly when the branch is taken
  localparam alu_op_t B_BNE     = 4'd10;
  localparam alu_op_t B_BLT     = 4'd11;
  localparam alu_op_t B_BGE     = 4'd12;
  localparam alu_op_t B_LTU     = 4'd13;
  localparam alu_op_t B_GEU     = 4'd14;
  localparam alu_op_t ALU_PASSB = 4'd15;

  // EX stage FSM
  typedef logic [0:0] ex_state_t;
  localparam ex_state_t StRun    = 1'b0;
  localparam ex_state_t StSquash = 1'b1;

  // A bypass source matches when it writes, targets rs, and rs is not x0.
  function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd == rs) && (rd != 5'd0);
  endfunction

  function automatic logic is_add_sub(input alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   op_i       - opcode (ex_stage_pkg encoding)
//   a_i, b_i   - left / right operands
//   result_o   - ALU result; for B_* opcodes 0 means "condition true"
//   zero_o     - result_o == 0
//   overflow_o - signed overflow of ALU_ADD / ALU_SUB
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        overflow_o
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;

  assign sum   = a_i + b_i;
  assign diff  = a_i - b_i;
  assign shamt = b_i[4:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o   = sum;
        overflow_o = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
      end
      ALU_SUB: begin
        result_o   = diff;
        overflow_o = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
      end
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:   result_o = {31'b0, lt_s};
      ALU_SLTU:  result_o = {31'b0, lt_u};
      // Branch compares drive the inverted condition so zero_o flags "taken".
      B_BNE:     result_o = {31'b0, a_i == b_i};
      B_BLT:     result_o = {31'b0, ~lt_s};
      B_BGE:     result_o = {31'b0, lt_s};
      B_LTU:     result_o = {31'b0, ~lt_u};
      B_GEU:     result_o = {31'b0, lt_u};
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and a one-entry
// output register with valid/ready handshake towards MEM.
// Optional feature macro: OVERFLOW_TRAP_EN (sticky signed-overflow trap).
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   id_valid / id_ready          - handshake from decode
//   id_control, id_is_branch     - opcode, conditional-branch flag
//   id_rs1/2, id_rs1/2_data      - source indices and register-file data
//   id_imm, id_use_imm, id_pc    - immediate, operand select, instruction PC
//   id_rd, id_reg_write          - destination and write enable
//   fwd_mem_*, fwd_wb_*          - bypass sources (MEM has priority)
//   mem_ready                    - downstream accepts ex_*
//   ex_valid, ex_result, ex_rd, ex_reg_write - registered result
//   branch_taken, branch_target  - one-cycle taken pulse and target
//   overflow_trap                - sticky overflow flag (0 when feature off)
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [3:0]  id_control,
  input  logic        id_is_branch,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic        id_use_imm,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        fwd_mem_we,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic        fwd_wb_we,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,
  input  logic        mem_ready,
  output logic        ex_valid,
  output logic [31:0] ex_result,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        overflow_trap
);

  ex_state_t   state_q, state_d;
  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_result_q, ex_result_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_reg_write_q, ex_reg_write_d;
  logic        branch_taken_q, branch_taken_d;
  logic [31:0] branch_target_q, branch_target_d;

  logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b;
  logic [31:0] alu_result;
  logic        alu_zero, alu_overflow;
  logic        squash, accept, taken, trap_hit;

  // Operand bypass: MEM > WB > register file
  always_comb begin
    if (fwd_hit(fwd_mem_we, fwd_mem_rd, id_rs1))     rs1_fwd = fwd_mem_data;
    else if (fwd_hit(fwd_wb_we, fwd_wb_rd, id_rs1))  rs1_fwd = fwd_wb_data;
    else                                             rs1_fwd = id_rs1_data;
    if (fwd_hit(fwd_mem_we, fwd_mem_rd, id_rs2))     rs2_fwd = fwd_mem_data;
    else if (fwd_hit(fwd_wb_we, fwd_wb_rd, id_rs2))  rs2_fwd = fwd_wb_data;
    else                                             rs2_fwd = id_rs2_data;
  end

  assign op_a = rs1_fwd;
  assign op_b = id_use_imm ? id_imm : rs2_fwd;

  ex_stage_alu u_alu (
    .op_i       (id_control),
    .a_i        (op_a),
    .b_i        (op_b),
    .result_o   (alu_result),
    .zero_o     (alu_zero),
    .overflow_o (alu_overflow)
  );

  // In SQUASH the wrong-path beat is swallowed, so the stage always looks ready.
  assign squash   = (state_q == StSquash);
  assign id_ready = squash | ~ex_valid_q | mem_ready;
  assign accept   = id_valid & id_ready & ~squash;
  assign taken    = id_is_branch & alu_zero;

`ifdef OVERFLOW_TRAP_EN
  logic trap_q;

  assign trap_hit = ~id_is_branch & is_add_sub(id_control) & alu_overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trap_q <= 1'b0;
    end else if (accept && trap_hit) begin
      trap_q <= 1'b1;
    end
  end

  assign overflow_trap = trap_q;
`else
  logic unused_overflow;

  assign unused_overflow = alu_overflow;
  assign trap_hit        = 1'b0;
  assign overflow_trap   = 1'b0;
`endif

  always_comb begin
    state_d = StRun;
    if (state_q == StRun && accept && taken) state_d = StSquash;
  end

  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_result_d     = ex_result_q;
    ex_rd_d         = ex_rd_q;
    ex_reg_write_d  = ex_reg_write_q;
    branch_taken_d  = 1'b0;
    branch_target_d = branch_target_q;
    // Accept wins over drain: a simultaneous accept and mem_ready replaces the entry.
    if (accept) begin
      ex_valid_d     = 1'b1;
      ex_result_d    = alu_result;
      ex_rd_d        = id_rd;
      ex_reg_write_d = id_reg_write & ~id_is_branch & ~trap_hit;
      branch_taken_d = taken;
      if (id_is_branch) branch_target_d = id_pc + id_imm;
    end else if (mem_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StRun;
      ex_valid_q      <= 1'b0;
      ex_result_q     <= '0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else begin
      state_q         <= state_d;
      ex_valid_q      <= ex_valid_d;
      ex_result_q     <= ex_result_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_write_q  <= ex_reg_write_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_result     = ex_result_q;
  assign ex_rd         = ex_rd_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;

endmodule
